// File: rtl/shift_arbiter_pkg.sv
// Shared types and constants for the two-requester shift arbiter.
// Contents: data/shift widths, FSM state encoding, requester IDs and the
// captured command payload.
package shift_arbiter_pkg;

    localparam int unsigned DW = 8;   // operand width
    localparam int unsigned SW = 3;   // shift-amount width, log2(DW)

    // FSM state encoding
    typedef logic [1:0] state_t;
    localparam state_t ST_IDLE  = 2'd0;
    localparam state_t ST_SHIFT = 2'd1;
    localparam state_t ST_RESP  = 2'd2;

    // Requester IDs
    localparam logic ID_A = 1'b0;
    localparam logic ID_B = 1'b1;

    // Command captured from the granted requester
    typedef struct packed {
        logic [DW-1:0] din;
        logic [SW-1:0] shamt;
        logic          lr;
        logic          al;
        logic          id;
    } cmd_t;

endpackage

// File: rtl/barrel_shift8.sv
// Purely combinational 8-bit barrel shifter, three stages (1/2/4).
// Ports:
//   din   - operand
//   shamt - shift amount 0..7
//   lr    - direction: 0 = right, 1 = left
//   al    - right-shift fill: 0 = zero, 1 = din[7] (ignored for left)
//   dout  - shifted result
module barrel_shift8
    import shift_arbiter_pkg::*;
(
    input  logic [DW-1:0] din,
    input  logic [SW-1:0] shamt,
    input  logic          lr,
    input  logic          al,
    output logic [DW-1:0] dout
);

    logic          fill;
    logic [DW-1:0] s1;
    logic [DW-1:0] s2;

    // Sign fill only applies to arithmetic right shifts
    assign fill = ~lr & al & din[DW-1];

    // Stage k shifts by 2^k when shamt[k] is set
    always_comb begin
        s1 = din;
        if (shamt[0]) s1 = lr ? {din[DW-2:0], 1'b0} : {fill, din[DW-1:1]};
        s2 = s1;
        if (shamt[1]) s2 = lr ? {s1[DW-3:0], 2'b00} : {{2{fill}}, s1[DW-1:2]};
        dout = s2;
        if (shamt[2]) dout = lr ? {s2[DW-5:0], 4'b0000} : {{4{fill}}, s2[DW-1:4]};
    end

endmodule

// File: rtl/shift_arbiter.sv
// Arbitrates two requesters onto one shared barrel shifter and returns the
// registered result, tagged with the requester ID, on one response channel.
// Ports:
//   clk, rst                         - clock, synchronous active-high reset
//   a_valid/a_ready/a_din/a_shamt/a_lr/a_al - requester A command channel
//   b_valid/b_ready/b_din/b_shamt/b_lr/b_al - requester B command channel
//   resp_valid/resp_ready/resp_dout/resp_id - response channel (id 0=A, 1=B)
// Build option: SHIFT_ARB_FIXED_PRIO_EN selects fixed priority (A wins ties)
// and removes the round-robin pointer; default is round robin.
module shift_arbiter
    import shift_arbiter_pkg::*;
(
    input  logic          clk,
    input  logic          rst,
    input  logic          a_valid,
    output logic          a_ready,
    input  logic [DW-1:0] a_din,
    input  logic [SW-1:0] a_shamt,
    input  logic          a_lr,
    input  logic          a_al,
    input  logic          b_valid,
    output logic          b_ready,
    input  logic [DW-1:0] b_din,
    input  logic [SW-1:0] b_shamt,
    input  logic          b_lr,
    input  logic          b_al,
    output logic          resp_valid,
    input  logic          resp_ready,
    output logic [DW-1:0] resp_dout,
    output logic          resp_id
);

    state_t        state_q, state_d;
    cmd_t          cmd_q, cmd_d;
    logic [DW-1:0] dout_q, dout_d;
    logic          id_q, id_d;
    logic          rvalid_q, rvalid_d;
    logic [DW-1:0] shift_dout;
    logic          gnt_a, gnt_b;

`ifndef SHIFT_ARB_FIXED_PRIO_EN
    logic          ptr_q, ptr_d;   // requester that wins a tie
`endif

    // Grant selection
`ifdef SHIFT_ARB_FIXED_PRIO_EN
    assign gnt_a = a_valid;
    assign gnt_b = b_valid & ~a_valid;
`else
    assign gnt_a = a_valid & (~b_valid | (ptr_q == ID_A));
    assign gnt_b = b_valid & (~a_valid | (ptr_q == ID_B));
`endif

    // Ready is a combinational grant, suppressed while reset is applied
    assign a_ready = ~rst & (state_q == ST_IDLE) & gnt_a;
    assign b_ready = ~rst & (state_q == ST_IDLE) & gnt_b;

    assign resp_valid = rvalid_q;
    assign resp_dout  = dout_q;
    assign resp_id    = id_q;

    barrel_shift8 u_shift (
        .din   (cmd_q.din),
        .shamt (cmd_q.shamt),
        .lr    (cmd_q.lr),
        .al    (cmd_q.al),
        .dout  (shift_dout)
    );

    // Next-state and register-update logic
    always_comb begin
        state_d  = state_q;
        cmd_d    = cmd_q;
        dout_d   = dout_q;
        id_d     = id_q;
        rvalid_d = rvalid_q;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
        ptr_d    = ptr_q;
`endif
        case (state_q)
            ST_IDLE: begin
                if (a_ready) begin
                    cmd_d   = '{din: a_din, shamt: a_shamt, lr: a_lr, al: a_al, id: ID_A};
                    state_d = ST_SHIFT;
                end else if (b_ready) begin
                    cmd_d   = '{din: b_din, shamt: b_shamt, lr: b_lr, al: b_al, id: ID_B};
                    state_d = ST_SHIFT;
                end
            end
            ST_SHIFT: begin
                dout_d   = shift_dout;
                id_d     = cmd_q.id;
                rvalid_d = 1'b1;
                state_d  = ST_RESP;
            end
            ST_RESP: begin
                if (resp_ready) begin
                    rvalid_d = 1'b0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
                    ptr_d    = ~id_q;   // hand the tie-break to the other side
`endif
                    state_d  = ST_IDLE;
                end
            end
            default: begin
                rvalid_d = 1'b0;
                state_d  = ST_IDLE;
            end
        endcase
    end

    // State registers
    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= ST_IDLE;
            cmd_q    <= '0;
            dout_q   <= '0;
            id_q     <= ID_A;
            rvalid_q <= 1'b0;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            ptr_q    <= ID_A;
`endif
        end else begin
            state_q  <= state_d;
            cmd_q    <= cmd_d;
            dout_q   <= dout_d;
            id_q     <= id_d;
            rvalid_q <= rvalid_d;
`ifndef SHIFT_ARB_FIXED_PRIO_EN
            ptr_q    <= ptr_d;
`endif
        end
    end

endmodule

// File: tb/tb_shift_arbiter.sv
// Directed self-checking bench for shift_arbiter with an expected-response queue.
module tb_shift_arbiter;
    import shift_arbiter_pkg::*;

    logic       clk = 1'b0;
    logic       rst;
    logic       a_valid, a_ready, a_lr, a_al;
    logic [7:0] a_din;
    logic [2:0] a_shamt;
    logic       b_valid, b_ready, b_lr, b_al;
    logic [7:0] b_din;
    logic [2:0] b_shamt;
    logic       resp_valid, resp_ready, resp_id;
    logic [7:0] resp_dout;

    typedef struct {
        logic       id;
        logic [7:0] dout;
    } exp_t;

    exp_t sb_q[$];
    int   n_vec = 0;
    int   n_err = 0;

    always #5 clk = ~clk;

    shift_arbiter dut (
        .clk        (clk),
        .rst        (rst),
        .a_valid    (a_valid),
        .a_ready    (a_ready),
        .a_din      (a_din),
        .a_shamt    (a_shamt),
        .a_lr       (a_lr),
        .a_al       (a_al),
        .b_valid    (b_valid),
        .b_ready    (b_ready),
        .b_din      (b_din),
        .b_shamt    (b_shamt),
        .b_lr       (b_lr),
        .b_al       (b_al),
        .resp_valid (resp_valid),
        .resp_ready (resp_ready),
        .resp_dout  (resp_dout),
        .resp_id    (resp_id)
    );

    // Reference shifter written arithmetically, independent of the stage structure
    function automatic logic [7:0] model(input logic [7:0] d, input logic [2:0] s,
                                         input logic lr, input logic al);
        if (lr) return 8'(d << s);
        if (al) return 8'($signed(d) >>> s);
        return 8'(d >> s);
    endfunction

    task automatic chk8(input string tag, input logic [7:0] obs, input logic [7:0] exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
        end
    endtask

    task automatic chk1(input string tag, input logic obs, input logic exp);
        n_vec++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s observed=%0b expected=%0b", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Run one command through the DUT: grant, SHIFT, RESP (with nbp stall cycles), handshake.
    // While stalled, B pulses valid and drops it again before the DUT is back in IDLE.
    task automatic serve(input logic id, input logic [7:0] exp_dout, input int nbp);
        exp_t e;
        resp_ready = (nbp == 0);
        #1;
        chk1("grant_a_ready", a_ready, id == ID_A);
        chk1("grant_b_ready", b_ready, id == ID_B);
        e.id   = id;
        e.dout = exp_dout;
        sb_q.push_back(e);
        tick();
        chk1("shift_resp_valid", resp_valid, 1'b0);
        chk1("shift_a_ready", a_ready, 1'b0);
        chk1("shift_b_ready", b_ready, 1'b0);
        tick();
        chk1("latency_resp_valid", resp_valid, 1'b1);
        for (int i = 0; i < nbp; i++) begin
            if (i == 0) begin
                b_valid = 1'b1;
                b_din   = 8'hFF;
                #1;
            end
            chk8("bp_dout_stable", resp_dout, sb_q[0].dout);
            chk1("bp_id_stable", resp_id, sb_q[0].id);
            chk1("bp_resp_valid", resp_valid, 1'b1);
            chk1("bp_a_ready", a_ready, 1'b0);
            chk1("bp_b_ready", b_ready, 1'b0);
            if (i == nbp - 1) b_valid = 1'b0;
            tick();
        end
        resp_ready = 1'b1;
        #1;
        e = sb_q.pop_front();
        chk1("resp_valid", resp_valid, 1'b1);
        chk8("resp_dout", resp_dout, e.dout);
        chk1("resp_id", resp_id, e.id);
        tick();
        chk1("post_hs_resp_valid", resp_valid, 1'b0);
    endtask

    task automatic check_idle(input int n);
        for (int i = 0; i < n; i++) begin
            chk1("idle_resp_valid", resp_valid, 1'b0);
            chk1("idle_a_ready", a_ready, 1'b0);
            chk1("idle_b_ready", b_ready, 1'b0);
            tick();
        end
    endtask

    // Watchdog: the directed sequence is fixed-length, this only guards against a hang.
    initial begin
        #200000;
        $display("FAIL watchdog observed=timeout expected=finish");
        $fatal(1, "timeout");
    end

    initial begin
        logic [7:0] rd;
        logic [2:0] rs;
        logic       rl, ra;

        // Reset with both requesters valid: readies and response must stay low
        rst = 1'b1; resp_ready = 1'b0;
        a_valid = 1'b1; a_din = 8'hB4; a_shamt = 3'd2; a_lr = 1'b0; a_al = 1'b0;
        b_valid = 1'b1; b_din = 8'hB4; b_shamt = 3'd2; b_lr = 1'b0; b_al = 1'b0;
        tick(); tick();
        chk1("rst_a_ready", a_ready, 1'b0);
        chk1("rst_b_ready", b_ready, 1'b0);
        chk1("rst_resp_valid", resp_valid, 1'b0);
        chk8("rst_resp_dout", resp_dout, 8'h00);
        chk1("rst_resp_id", resp_id, 1'b0);
        rst = 1'b0; a_valid = 1'b0; b_valid = 1'b0;
        #1;
        check_idle(2);

        // Right logical from A
        a_valid = 1'b1; a_din = 8'hB4; a_shamt = 3'd2; a_lr = 1'b0; a_al = 1'b0;
        serve(ID_A, 8'h2D, 0);
        a_valid = 1'b0;

        // Right arithmetic then left from B, valid held back-to-back
        b_valid = 1'b1; b_din = 8'hB4; b_shamt = 3'd2; b_lr = 1'b0; b_al = 1'b1;
        serve(ID_B, 8'hED, 0);
        b_din = 8'hB4; b_shamt = 3'd3; b_lr = 1'b1; b_al = 1'b1;
        serve(ID_B, 8'hA0, 0);
        b_valid = 1'b0;

        // Edge shift amounts, one with backpressure
        a_valid = 1'b1; a_din = 8'h81; a_shamt = 3'd0; a_lr = 1'b0; a_al = 1'b0;
        serve(ID_A, 8'h81, 0);
        a_din = 8'h80; a_shamt = 3'd7; a_lr = 1'b0; a_al = 1'b1;
        serve(ID_A, 8'hFF, 5);
        a_valid = 1'b0;
        #1;
        check_idle(3);
        b_valid = 1'b1; b_din = 8'h01; b_shamt = 3'd7; b_lr = 1'b1; b_al = 1'b0;
        serve(ID_B, 8'h80, 0);
        b_valid = 1'b0;

        // Arbitration with both requesters valid from reset
        rst = 1'b1; resp_ready = 1'b0;
        a_valid = 1'b1; a_din = 8'h3C; a_shamt = 3'd1; a_lr = 1'b1; a_al = 1'b0;
        b_valid = 1'b1; b_din = 8'hC3; b_shamt = 3'd4; b_lr = 1'b0; b_al = 1'b1;
        tick();
        rst = 1'b0;
        serve(ID_A, 8'h78, 0);
`ifdef SHIFT_ARB_FIXED_PRIO_EN
        serve(ID_A, 8'h78, 0);
`else
        serve(ID_B, 8'hFC, 0);
`endif
        serve(ID_A, 8'h78, 0);
        a_valid = 1'b0; b_valid = 1'b0;

        // Reset during SHIFT discards the command and returns the tie-break to A
        resp_ready = 1'b1;
        a_valid = 1'b1; a_din = 8'h81; a_shamt = 3'd0; a_lr = 1'b0; a_al = 1'b0;
        #1;
        chk1("pre_rst_a_ready", a_ready, 1'b1);
        tick();
        a_valid = 1'b0; rst = 1'b1;
        #1;
        chk1("rst_shift_resp_valid", resp_valid, 1'b0);
        tick();
        rst = 1'b0;
        #1;
        check_idle(4);
        a_valid = 1'b1; a_din = 8'h3C; a_shamt = 3'd1; a_lr = 1'b1; a_al = 1'b0;
        b_valid = 1'b1; b_din = 8'hC3; b_shamt = 3'd4; b_lr = 1'b0; b_al = 1'b1;
        serve(ID_A, 8'h78, 0);
        a_valid = 1'b0; b_valid = 1'b0;

        // Random commands from A against the reference shifter
        for (int i = 0; i < 16; i++) begin
            rd = 8'($urandom_range(0, 255));
            rs = 3'($urandom_range(0, 7));
            rl = 1'($urandom_range(0, 1));
            ra = 1'($urandom_range(0, 1));
            a_valid = 1'b1; a_din = rd; a_shamt = rs; a_lr = rl; a_al = ra;
            serve(ID_A, model(rd, rs, rl, ra), 0);
        end
        a_valid = 1'b0;

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule

// File: doc/shift_arbiter.md
Name: shift_arbiter

Overview:
- Shares one 8-bit barrel shifter between two requesters, A and B.
- Each requester issues shift commands (data, shift amount, direction, arithmetic/logical) over a valid/ready handshake.
- The block arbitrates between them, captures the granted command, registers the shift result, and returns it on a single response channel tagged with the requester ID.
- It sits between the lab's input/control logic and the shifter datapath, and is the only driver of that datapath.

Parameters:
- DW, 8, data width; fixed at 8 for this revision.
- SW, 3, shift-amount width, equal to log2(DW).

Ports:
- clk  input  1  system clock; all state updates on rising edge.
- rst  input  1  synchronous, active-high reset.
- a_valid  input  1  requester A command valid.
- a_ready  output  1  requester A command accepted this cycle.
- a_din  input  8  requester A operand.
- a_shamt  input  3  requester A shift amount, 0..7.
- a_lr  input  1  requester A direction: 0 = right, 1 = left.
- a_al  input  1  requester A right-shift fill: 0 = logical (zero), 1 = arithmetic (din[7]).
- b_valid, b_ready, b_din, b_shamt, b_lr, b_al: same widths and meaning, for requester B.
- resp_valid  output  1  result available.
- resp_ready  input  1  consumer accepts result.
- resp_dout  output  8  shifted result.
- resp_id  output  1  requester that issued the result: 0 = A, 1 = B.

Behaviour:
- Reset: clk and rst as above; the reset is synchronous and active-high.
  - In the cycle rst is high, all state is forced to its reset value.
  - Reset values: state=IDLE, priority pointer=A, a_ready=0, b_ready=0, resp_valid=0, resp_dout=0x00, resp_id=0.
- FSM has three states: IDLE, SHIFT, RESP.
- IDLE:
  - Grant = highest-priority requester with valid=1.
  - Grant's ready is driven combinationally high (ready = state==IDLE && granted).
  - On valid&&ready, capture din/shamt/lr/al/id into the command register, then go to SHIFT.
  - No valid: stay in IDLE; both readies stay 0.
- SHIFT: the shifter computes from the command register; the result is registered into resp_dout, resp_id is set, then go to RESP.
- RESP:
  - resp_valid=1; resp_dout and resp_id are held stable until resp_ready=1.
  - On handshake: clear resp_valid, update the pointer to the requester not just served, go to IDLE.
- Latency and throughput:
  - Accept in cycle T gives resp_valid high at cycle T+2.
  - With resp_ready held high, throughput is one command per 3 cycles.
- Shift semantics:
  - shamt=0 passes the operand through.
  - Right logical fills with 0; right arithmetic fills with din[7].
  - Left always fills with 0; al is ignored when lr=1.
- Round robin: if both are valid in IDLE, the pointer side wins. After each completed response, the pointer points to the other requester, regardless of whether it is valid.
- Boundary conditions:
  - A requester dropping valid before grant is legal; nothing is captured.
  - Requester inputs are ignored outside IDLE, and both readies are 0 there.
  - resp_ready asserted while resp_valid=0 has no effect.
  - Reset in SHIFT or RESP discards the in-flight command; no response is emitted.

Optional Feature:
- Macro: SHIFT_ARB_FIXED_PRIO_EN.
- Defined: fixed priority, A always wins simultaneous requests; the pointer register is removed.
- Undefined (default): round-robin as above.

Decomposition:
- Shared package contents:
  - FSM state typedef (IDLE, SHIFT, RESP).
  - Requester-ID constants ID_A=0, ID_B=1.
  - Command struct {din[7:0], shamt[2:0], lr, al, id}.
  - DW/SW constants.
- One sub-module, barrel_shift8: a purely combinational 3-stage (1/2/4) shifter with inputs din, shamt, lr, al and output dout.
- Arbitration, FSM and registers live in shift_arbiter.

Test Plan:
- Right logical: A sends din=0xB4, shamt=2, lr=0, al=0; resp_ready=1 → resp_valid at accept+2, resp_dout=0x2D, resp_id=0.
- Right arithmetic and left shift:
  - B sends 0xB4, shamt=2, lr=0, al=1 → 0xED, id=1.
  - Then B sends 0xB4, shamt=3, lr=1, al=1 → 0xA0.
- Arbitration: A and B both valid from reset, held until ready → A served first, then B, then A.
  - With SHIFT_ARB_FIXED_PRIO_EN defined → A, A, A; B is never granted while A stays valid.
- Backpressure: resp_ready=0 for 5 cycles after resp_valid → resp_dout/resp_id stable, a_ready=b_ready=0 throughout; then resp_ready=1 → one handshake, return to IDLE.
- Reset mid-operation: assert rst in the SHIFT cycle → next cycle resp_valid=0, state IDLE, pointer=A, no response for the discarded command.
- Edge amounts:
  - shamt=0, din=0x81 → 0x81.
  - shamt=7, lr=0, al=1, din=0x80 → 0xFF.
  - shamt=7, lr=1, din=0x01 → 0x80.
